// File: rtl/audio_pkg.sv
// Shared definitions for the audio tone generator: FSM state encoding,
// chromatic note table (C4..D#5) and the half-period helper.
package audio_pkg;

  // Controller states; ST_IDLE is the only state with the tone path held off.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_PLAY = 2'd2
  } audio_state_e;

  localparam int NUM_NOTES = 16;
  localparam int TONE_W    = 20;
  localparam int VOL_W     = 5;
  localparam int SEL_W     = 4;

  // Note frequencies in Hz, index 0 = C4 up to index 15 = D#5.
  localparam int unsigned NOTE_HZ [NUM_NOTES] = '{
    262, 277, 294, 311, 330, 349, 370, 392,
    415, 440, 466, 494, 523, 554, 587, 622
  };

  // Clock cycles per half wave of the selected note, rounded down.
  // Only ever called with constant arguments, so it folds to a constant.
  function automatic logic [TONE_W-1:0] half_period(input int unsigned clk_hz,
                                                    input logic [SEL_W-1:0] sel);
    int unsigned q;
    q = clk_hz / (2 * NOTE_HZ[sel]);
    return q[TONE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_pwm.sv
// Volume modulator: a free-running 5-bit counter compared against the
// current volume gates the square-wave level. Output is registered.
module audio_pwm
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             level,
  input  logic [VOL_W-1:0] vol,
  output logic             pwm_out
);

  logic [VOL_W-1:0] pwm_cnt;

  // Free-running counter and registered compare; vol = 0 can never win the
  // compare, vol = 31 wins on 31 of every 32 counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= level && (pwm_cnt < vol);
    end
  end

endmodule

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator with ramped volume for a speaker pin.
// Inputs are registered once; a three-state controller (IDLE/RAMP/PLAY)
// walks cur_vol one step per RAMP_DIV cycles toward the target, a 20-bit
// tone counter produces the note, and audio_pwm scales it by volume.
// The controller state is held in the named register 'state' of type
// audio_state_e so checkers can bind to it directly.
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 25000000,
  parameter int unsigned RAMP_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             audioEn,
  input  logic [SEL_W-1:0] audioSel,
  input  logic [VOL_W-1:0] audioVol,
  output logic             audio_out,
  output logic             audio_busy,
  output logic [VOL_W-1:0] cur_vol
);

  localparam int          RAMP_W    = 16;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  // Registered copies of the processor register fields.
  logic             en_r;
  logic [SEL_W-1:0] sel_r;
  logic [VOL_W-1:0] vol_r;

  logic [VOL_W-1:0] target;
  logic [VOL_W-1:0] vol_n;
  logic [VOL_W-1:0] vol_step;

  audio_state_e      state;
  audio_state_e      state_n;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [RAMP_W-1:0] ramp_n;

  logic [TONE_W-1:0] tone_cnt;
  logic [TONE_W-1:0] half_cur;
  logic              tone_level;

  // Half-period lookup, one constant per note.
  logic [TONE_W-1:0] half_tab [NUM_NOTES];

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_half
    assign half_tab[gi] = half_period(CLK_HZ, SEL_W'(gi));
  end

  // Capture the processor register fields; everything downstream uses these.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r  <= 1'b0;
      sel_r <= '0;
      vol_r <= '0;
    end else begin
      en_r  <= audioEn;
      sel_r <= audioSel;
      vol_r <= audioVol;
    end
  end

  // Disabling the tone is just a ramp toward zero.
  assign target = en_r ? vol_r : '0;

  // Next-state, next-volume and ramp divider logic. A ramp step always uses
  // the target seen at that moment, so a mid-ramp target change (even one
  // that reverses direction) continues from the present cur_vol. Reaching a
  // zero target drops back to IDLE, a nonzero one settles in PLAY.
  always_comb begin
    state_n  = state;
    vol_n    = cur_vol;
    ramp_n   = '0;
    vol_step = (target > cur_vol) ? cur_vol + 5'd1 : cur_vol - 5'd1;
    case (state)
      ST_IDLE: begin
        if (target != cur_vol) state_n = ST_RAMP;
      end
      ST_RAMP: begin
        if (cur_vol == target) begin
          state_n = (target != '0) ? ST_PLAY : ST_IDLE;
        end else if (ramp_cnt == RAMP_LAST) begin
          vol_n = vol_step;
          if (vol_step == target) state_n = (target != '0) ? ST_PLAY : ST_IDLE;
        end else begin
          ramp_n = ramp_cnt + 1'b1;
        end
      end
      ST_PLAY: begin
        if (target != cur_vol) state_n = ST_RAMP;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset aborts any tone or ramp immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_vol  <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_n;
      cur_vol  <= vol_n;
      ramp_cnt <= ramp_n;
    end
  end

  // Tone counter: held at zero in IDLE (while tracking the selected note),
  // otherwise counts to half_cur-1, wraps and toggles the level. A new note
  // is only adopted at a wrap, so note changes never cut a half wave short.
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt   <= '0;
      tone_level <= 1'b0;
      half_cur   <= half_tab[4'd0];
    end else if (state == ST_IDLE) begin
      tone_cnt   <= '0;
      tone_level <= 1'b0;
      half_cur   <= half_tab[sel_r];
    end else if (tone_cnt == half_cur - 20'd1) begin
      tone_cnt   <= '0;
      tone_level <= ~tone_level;
      half_cur   <= half_tab[sel_r];
    end else begin
      tone_cnt   <= tone_cnt + 20'd1;
    end
  end

  assign audio_busy = (state != ST_IDLE);

  audio_pwm u_pwm (
    .clk     (clk),
    .reset   (reset),
    .level   (tone_level),
    .vol     (cur_vol),
    .pwm_out (audio_out)
  );

endmodule
